writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  MEM/WB pipeline register plus result select for the MIPS pipeline. Sits directly upstream
//  of the 32x32 register file and drives its write_address/write_data_in/WriteEnable.
//  Captures the memory-stage result, aligns and extends load data, and suppresses writes to $0.
//  Publishes the same write for EX forwarding, and counts retired instructions for debug.
// PARAMETERS
//  RETIRE_CNT_WIDTH  32  width of retired-instruction counter (wraps)
//  BIG_ENDIAN        1   1: byte offset 0 = bits[31:24]; 0: byte offset 0 = bits[7:0]
// PORTS
//  clock            in   1   single pipeline clock (register file writes on its negedge)
//  reset            in   1   asynchronous, active-low reset
//  stall            in   1   hold WB register contents this cycle
//  flush            in   1   kill the instruction being captured this cycle
//  in_valid         in   1   MEM stage holds a real instruction
//  in_reg_write     in   1   instruction writes a GPR
//  in_dest          in   5   destination GPR number
//  in_wb_sel        in   2   result source: 0 ALU, 1 MEM, 2 LINK, 3 reserved
//  in_alu_result    in   32  ALU result (also the load effective address)
//  in_mem_data      in   32  raw data-memory read word
//  in_pc_plus8      in   32  link value for JAL/JALR/BGEZAL
//  in_load_size     in   2   0 word, 1 half, 2 byte, 3 reserved
//  in_load_unsigned in   1   1: zero-extend (LBU/LHU); 0: sign-extend
//  write_address    out  5   to register file
//  write_data_in    out  32  to register file
//  WriteEnable      out  1   to register file
//  wb_valid         out  1   WB register holds a live instruction
//  load_misaligned  out  1   live load with illegal alignment (write suppressed)
//  retired_count    out  RETIRE_CNT_WIDTH  instructions retired since reset
// BEHAVIOUR
//  - Reset (reset==0, async): wb_valid=0, all WB fields 0, retired_count=0. Hence
//    WriteEnable=0, write_address=0, write_data_in=0, load_misaligned=0.
//  - posedge clock, reset high:
//    flush=1        -> wb_valid<=0, other fields 0. Flush wins over stall.
//    stall=1        -> all WB fields hold.
//    otherwise      -> capture all in_* fields; wb_valid<=in_valid.
//  - Latency: input captured at edge N. Outputs valid after edge N (combinational from
//    WB register). Register file commits at the following negedge. A same-cycle decode
//    read therefore sees the new value.
//  - Byte offset = alu_result[1:0] (registered).
//    Half: offset[0]=1 is misaligned. Word: offset!=0 is misaligned.
//    Byte and non-MEM sel never misalign.
//    load_misaligned = wb_valid & sel==MEM & misaligned.
//  - Load extract (BIG_ENDIAN=1):
//    byte k -> bits[31-8k -: 8].
//    half at offset 0 -> [31:16]; half at offset 2 -> [15:0].
//    Extend to 32 per in_load_unsigned. Word passes through.
//  - write_data_in: sel 0 alu_result, 1 extracted load, 2 pc_plus8, 3 -> 32'h0.
//  - WriteEnable = wb_valid & reg_write & (dest!=0) & !load_misaligned & (sel!=3).
//    write_address = dest whenever wb_valid, else 0.
//  - Stall with a live write keeps WriteEnable asserted. The repeated write is idempotent.
//  - retired_count increments by 1 on a posedge where wb_valid=1 and stall=0, including
//    flush edges (flush kills the incoming instruction, not the retiring one). Wraps 2^W-1 -> 0.
//    Misaligned loads still retire.
//  - Reset asserted mid-stall or mid-write clears immediately; no write survives it.
// STRUCTURE
//  - Shared package/header mips_defs: WB_SEL_ALU/MEM/LINK/RSVD, LOAD_WORD/HALF/BYTE,
//    and GPR_ZERO = 5'd0.
//  - One sub-module: load_extender (combinational).
//    Inputs: mem_data, offset, size, unsigned. Outputs: data, misaligned.
//  - Top holds the WB register, the select mux, the write gating and the counter.
// TESTING
//  1. ALU write: in_valid=1, reg_write=1, dest=8, sel=0, alu=32'h1234 -> next cycle
//     WriteEnable=1, addr=8, data=32'h1234, retired_count=1 after the next edge.
//  2. Loads, mem=32'h80FF7F01: LB off0 -> FFFFFF80; LBU off0 -> 00000080;
//     LH off2 -> 00007F01; LHU off0 -> 000080FF; LH off1 -> WriteEnable=0, misaligned=1.
//  3. $0 guard: reg_write=1, dest=0, alu=32'hDEAD -> WriteEnable=0, wb_valid=1, still retires.
//  4. Link: sel=2, dest=31, pc_plus8=32'h00400010 -> addr=31, data=32'h00400010.
//  5. Stall/flush: hold stall 3 cycles -> outputs frozen, count unchanged.
//     stall+flush same edge -> wb_valid=0. Async reset low mid-cycle -> WriteEnable=0 at once.
//  6. Counter wrap: RETIRE_CNT_WIDTH=4, retire 17 instructions -> retired_count=1.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: writeback select codes, load sizes, GPR constants.
package mips_defs;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2,
    WB_SEL_RSVD = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LOAD_WORD = 2'd0,
    LOAD_HALF = 2'd1,
    LOAD_BYTE = 2'd2,
    LOAD_RSVD = 2'd3
  } load_size_e;

  localparam logic [4:0] GPR_ZERO = 5'd0;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  dest;
    wb_sel_e     sel;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc_plus8;
    load_size_e  load_size;
    logic        load_unsigned;
  } wb_reg_t;

endpackage

// File: rtl/load_extender.sv
// Combinational load aligner: picks the addressed byte/half from the memory word,
// sign- or zero-extends it, and flags illegal alignment.
module load_extender
  import mips_defs::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] mem_data,
  input  logic [1:0]  offset,
  input  load_size_e  size,
  input  logic        load_unsigned,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [1:0]  lane;
  logic        half_hi;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Lane selection, extension and alignment check; reserved size behaves as a word.
  always_comb begin
    lane       = BIG_ENDIAN ? (2'd3 - offset) : offset;
    half_hi    = BIG_ENDIAN ? ~offset[1] : offset[1];
    byte_val   = mem_data[{lane, 3'b000} +: 8];
    half_val   = half_hi ? mem_data[31:16] : mem_data[15:0];
    data       = mem_data;
    misaligned = 1'b0;
    case (size)
      LOAD_BYTE: data = {{24{~load_unsigned & byte_val[7]}}, byte_val};
      LOAD_HALF: begin
        data       = {{16{~load_unsigned & half_val[15]}}, half_val};
        misaligned = offset[0];
      end
      default:   misaligned = (offset != 2'd0);
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, result select and register-file write gating,
// plus a retired-instruction counter for debug.
module writeback_stage
  import mips_defs::*;
#(
  parameter int unsigned RETIRE_CNT_WIDTH = 32,
  parameter bit          BIG_ENDIAN       = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic                        in_reg_write,
  input  logic [4:0]                  in_dest,
  input  logic [1:0]                  in_wb_sel,
  input  logic [31:0]                 in_alu_result,
  input  logic [31:0]                 in_mem_data,
  input  logic [31:0]                 in_pc_plus8,
  input  logic [1:0]                  in_load_size,
  input  logic                        in_load_unsigned,
  output logic [4:0]                  write_address,
  output logic [31:0]                 write_data_in,
  output logic                        WriteEnable,
  output logic                        wb_valid,
  output logic                        load_misaligned,
  output logic [RETIRE_CNT_WIDTH-1:0] retired_count
);

  wb_reg_t     wb_q;
  wb_reg_t     wb_d;
  logic [31:0] load_data;
  logic        ext_misaligned;
  logic        misaligned_live;

  // Pack the incoming MEM-stage fields into the register format.
  always_comb begin
    wb_d               = '0;
    wb_d.valid         = in_valid;
    wb_d.reg_write     = in_reg_write;
    wb_d.dest          = in_dest;
    wb_d.sel           = wb_sel_e'(in_wb_sel);
    wb_d.alu_result    = in_alu_result;
    wb_d.mem_data      = in_mem_data;
    wb_d.pc_plus8      = in_pc_plus8;
    wb_d.load_size     = load_size_e'(in_load_size);
    wb_d.load_unsigned = in_load_unsigned;
  end

  // WB register: flush clears (and beats stall), stall holds, otherwise capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q <= '0;
    end else if (!stall) begin
      wb_q <= wb_d;
    end
  end

  load_extender #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_load_extender (
    .mem_data     (wb_q.mem_data),
    .offset       (wb_q.alu_result[1:0]),
    .size         (wb_q.load_size),
    .load_unsigned(wb_q.load_unsigned),
    .data         (load_data),
    .misaligned   (ext_misaligned)
  );

  // Result select and write gating driven straight from the WB register.
  always_comb begin
    misaligned_live = wb_q.valid && (wb_q.sel == WB_SEL_MEM) && ext_misaligned;
    case (wb_q.sel)
      WB_SEL_ALU:  write_data_in = wb_q.alu_result;
      WB_SEL_MEM:  write_data_in = load_data;
      WB_SEL_LINK: write_data_in = wb_q.pc_plus8;
      default:     write_data_in = '0;
    endcase
    wb_valid        = wb_q.valid;
    load_misaligned = misaligned_live;
    write_address   = wb_q.valid ? wb_q.dest : GPR_ZERO;
    WriteEnable     = wb_q.valid && wb_q.reg_write && (wb_q.dest != GPR_ZERO) &&
                      !misaligned_live && (wb_q.sel != WB_SEL_RSVD);
  end

  // Count the instruction leaving WB; a flush kills only the incoming one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_count <= '0;
    end else if (wb_q.valid && !stall) begin
      retired_count <= retired_count + RETIRE_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table, hand sequences for
// stall/flush/reset/wrap, and randomized traffic against a behavioural model.
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic        in_valid, in_reg_write;
  logic [4:0]  in_dest;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result, in_mem_data, in_pc_plus8;
  logic [1:0]  in_load_size;
  logic        in_load_unsigned;

  logic [4:0]  write_address, write_address_4;
  logic [31:0] write_data_in, write_data_in_4;
  logic        WriteEnable, WriteEnable_4;
  logic        wb_valid, wb_valid_4;
  logic        load_misaligned, load_misaligned_4;
  logic [31:0] retired_count;
  logic [3:0]  retired_count_4;

  always #5 clock = ~clock;

  writeback_stage #(.RETIRE_CNT_WIDTH(32), .BIG_ENDIAN(1'b1)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_dest(in_dest),
    .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_pc_plus8(in_pc_plus8), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned),
    .write_address(write_address), .write_data_in(write_data_in),
    .WriteEnable(WriteEnable), .wb_valid(wb_valid),
    .load_misaligned(load_misaligned), .retired_count(retired_count)
  );

  writeback_stage #(.RETIRE_CNT_WIDTH(4), .BIG_ENDIAN(1'b1)) dut4 (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_dest(in_dest),
    .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_pc_plus8(in_pc_plus8), .in_load_size(in_load_size),
    .in_load_unsigned(in_load_unsigned),
    .write_address(write_address_4), .write_data_in(write_data_in_4),
    .WriteEnable(WriteEnable_4), .wb_valid(wb_valid_4),
    .load_misaligned(load_misaligned_4), .retired_count(retired_count_4)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model of what the WB stage currently holds.
  typedef struct {
    bit        valid, rw;
    bit [4:0]  dest;
    bit [1:0]  sel;
    bit [31:0] alu, mem, pc8;
    bit [1:0]  size;
    bit        uns;
  } model_t;

  model_t      m;
  int unsigned m_count;

  typedef struct {
    bit        valid, rw;
    bit [4:0]  dest;
    bit [1:0]  sel;
    bit [31:0] alu, mem, pc8;
    bit [1:0]  size;
    bit        uns;
    bit        exp_we;
    bit [4:0]  exp_addr;
    bit        chk_data;
    bit [31:0] exp_data;
    bit        exp_mis;
  } vec_t;

  function automatic bit [31:0] model_load(bit [31:0] mem, bit [1:0] off, bit [1:0] size, bit uns);
    int unsigned v, nbits, o;
    o = off;
    if (size == 2) begin
      v = (mem >> (8 * (3 - o))) % 256;
      nbits = 8;
    end else if (size == 1) begin
      v = (mem >> (16 * (1 - o / 2))) % 65536;
      nbits = 16;
    end else begin
      return mem;
    end
    if (!uns && v >= (32'd1 << (nbits - 1))) v = v - (32'd1 << nbits);
    return v;
  endfunction

  function automatic bit model_mis(model_t s);
    int unsigned o;
    o = s.alu % 4;
    if (!s.valid || s.sel != 1) return 1'b0;
    if (s.size == 1) return (o % 2) == 1;
    if (s.size == 2) return 1'b0;
    return o != 0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit        mis, we;
    bit [31:0] data;
    mis = model_mis(m);
    case (m.sel)
      2'd0: data = m.alu;
      2'd1: data = model_load(m.mem, m.alu[1:0], m.size, m.uns);
      2'd2: data = m.pc8;
      default: data = 32'h0;
    endcase
    we = m.valid && m.rw && (m.dest != 0) && !mis && (m.sel != 3);
    check("wb_valid", {31'b0, wb_valid}, {31'b0, m.valid});
    check("WriteEnable", {31'b0, WriteEnable}, {31'b0, we});
    check("write_address", {27'b0, write_address}, m.valid ? {27'b0, m.dest} : 32'h0);
    check("write_data_in", write_data_in, data);
    check("load_misaligned", {31'b0, load_misaligned}, {31'b0, mis});
    check("retired_count", retired_count, m_count);
    check("retired_count_w4", {28'b0, retired_count_4}, m_count % 16);
  endtask

  task automatic drive(bit v, bit rw, bit [4:0] d, bit [1:0] sel, bit [31:0] alu,
                       bit [31:0] mem, bit [31:0] pc8, bit [1:0] size, bit uns);
    in_valid = v; in_reg_write = rw; in_dest = d; in_wb_sel = sel;
    in_alu_result = alu; in_mem_data = mem; in_pc_plus8 = pc8;
    in_load_size = size; in_load_unsigned = uns;
  endtask

  // One clock edge: advance the model with the rules of the stage, then sample.
  task automatic step();
    @(posedge clock);
    if (m.valid && !stall) m_count++;
    if (flush) m = '{default: 0};
    else if (!stall) begin
      m.valid = in_valid; m.rw = in_reg_write; m.dest = in_dest; m.sel = in_wb_sel;
      m.alu = in_alu_result; m.mem = in_mem_data; m.pc8 = in_pc_plus8;
      m.size = in_load_size; m.uns = in_load_unsigned;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    m = '{default: 0};
    m_count = 0;
    #3;
    check_model();
    @(negedge clock);
    reset = 1'b1;
  endtask

  vec_t vecs[$];
  int unsigned cnt0;

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m = '{default: 0};
    m_count = 0;
    #1 reset = 1'b0;
    #2;
    check("reset_we", {31'b0, WriteEnable}, 32'h0);
    check("reset_valid", {31'b0, wb_valid}, 32'h0);
    check("reset_count", retired_count, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // valid rw dest sel alu mem pc8 size uns | we addr chk data mis
    vecs.push_back('{1,1, 8,0,32'h1234,    32'h0,        32'h0,       0,0, 1, 8,1,32'h1234,    0});
    vecs.push_back('{1,1, 9,1,32'h100,     32'h80FF7F01, 32'h0,       2,0, 1, 9,1,32'hFFFFFF80,0});
    vecs.push_back('{1,1, 9,1,32'h100,     32'h80FF7F01, 32'h0,       2,1, 1, 9,1,32'h00000080,0});
    vecs.push_back('{1,1, 9,1,32'h102,     32'h80FF7F01, 32'h0,       1,0, 1, 9,1,32'h00007F01,0});
    vecs.push_back('{1,1, 9,1,32'h100,     32'h80FF7F01, 32'h0,       1,1, 1, 9,1,32'h000080FF,0});
    vecs.push_back('{1,1, 9,1,32'h101,     32'h80FF7F01, 32'h0,       1,0, 0, 9,0,32'h0,       1});
    vecs.push_back('{1,1,10,1,32'h200,     32'h80FF7F01, 32'h0,       0,0, 1,10,1,32'h80FF7F01,0});
    vecs.push_back('{1,1,10,1,32'h203,     32'h80FF7F01, 32'h0,       2,0, 1,10,1,32'h00000001,0});
    vecs.push_back('{1,1,10,1,32'h201,     32'h80FF7F01, 32'h0,       2,0, 1,10,1,32'hFFFFFFFF,0});
    vecs.push_back('{1,1,10,1,32'h202,     32'h80FF7F01, 32'h0,       2,1, 1,10,1,32'h0000007F,0});
    vecs.push_back('{1,1,10,1,32'h202,     32'h80FF7F01, 32'h0,       0,0, 0,10,0,32'h0,       1});
    vecs.push_back('{1,1, 0,0,32'hDEAD,    32'h0,        32'h0,       0,0, 0, 0,1,32'hDEAD,    0});
    vecs.push_back('{1,1,31,2,32'h0,       32'h0,        32'h00400010,0,0, 1,31,1,32'h00400010,0});
    vecs.push_back('{1,1, 5,3,32'h77,      32'h0,        32'h0,       0,0, 0, 5,1,32'h0,       0});
    vecs.push_back('{0,1, 5,0,32'h55,      32'h0,        32'h0,       0,0, 0, 0,1,32'h55,      0});
    vecs.push_back('{0,1, 5,1,32'h101,     32'h80FF7F01, 32'h0,       1,0, 0, 0,0,32'h0,       0});

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].rw, vecs[i].dest, vecs[i].sel, vecs[i].alu,
            vecs[i].mem, vecs[i].pc8, vecs[i].size, vecs[i].uns);
      step();
      check($sformatf("vec%0d_we", i), {31'b0, WriteEnable}, {31'b0, vecs[i].exp_we});
      check($sformatf("vec%0d_addr", i), {27'b0, write_address}, {27'b0, vecs[i].exp_addr});
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_data", i), write_data_in, vecs[i].exp_data);
      check($sformatf("vec%0d_mis", i), {31'b0, load_misaligned}, {31'b0, vecs[i].exp_mis});
      check_model();
    end

    // First instruction after reset retires on the following edge.
    do_reset();
    drive(1, 1, 8, 0, 32'h1234, 0, 0, 0, 0);
    step();
    check("t1_count_before", retired_count, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("t1_count_after", retired_count, 32'd1);

    // Stall holds a live write for three cycles with no retirement.
    drive(1, 1, 3, 0, 32'hA5A5, 0, 0, 0, 0);
    step();
    cnt0 = m_count;
    stall = 1'b1;
    drive(1, 1, 7, 2, 32'h1111, 0, 32'h2222, 0, 0);
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      check("stall_we", {31'b0, WriteEnable}, 32'h1);
      check("stall_addr", {27'b0, write_address}, 32'd3);
      check("stall_data", write_data_in, 32'hA5A5);
      check("stall_count", retired_count, cnt0);
    end
    flush = 1'b1;
    step();
    check("stall_flush_valid", {31'b0, wb_valid}, 32'h0);
    check("stall_flush_count", retired_count, cnt0);
    stall = 1'b0; flush = 1'b0;
    check_model();

    // Flush alone still retires the instruction already in WB.
    drive(1, 1, 4, 0, 32'h4444, 0, 0, 0, 0);
    step();
    cnt0 = m_count;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", {31'b0, wb_valid}, 32'h0);
    check("flush_count", retired_count, cnt0 + 1);

    // Asynchronous reset mid-write clears outputs immediately.
    drive(1, 1, 6, 0, 32'h6666, 0, 0, 0, 0);
    step();
    check("pre_reset_we", {31'b0, WriteEnable}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async_we", {31'b0, WriteEnable}, 32'h0);
    check("async_valid", {31'b0, wb_valid}, 32'h0);
    check("async_addr", {27'b0, write_address}, 32'h0);
    check("async_data", write_data_in, 32'h0);
    check("async_count", retired_count, 32'h0);
    m = '{default: 0};
    m_count = 0;
    @(negedge clock);
    reset = 1'b1;

    // 4-bit counter wraps: 17 retirements land on 1.
    drive(1, 0, 2, 0, 0, 0, 0, 0, 0);
    for (int unsigned k = 0; k < 17; k++) step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("wrap_count4", {28'b0, retired_count_4}, 32'd1);
    check("wrap_count32", retired_count, 32'd17);

    // Randomized traffic against the model.
    for (int unsigned k = 0; k < 600; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
            2'($urandom_range(0, 2)), $urandom_range(0, 1));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      step();
      check_model();
    end
    stall = 1'b0; flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
